water_tank_level_encoder: RTL and testbench
===========================================

WATER_TANK_LEVEL_ENCODER -- requirements
Module: water_tank_level_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples required before a level or fault is committed (legal range 2..255).
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 level_sensors  input  3  asynchronous probe inputs: [0] low probe, [1] mid probe, [2] high probe (1 = wet).
REQ-005 tank_level_status  output  2  committed level code: 2'b11 empty, 2'b10 low, 2'b01 mid, 2'b00 full.
REQ-006 level_changed  output  1  one-cycle pulse on every commit that changes tank_level_status.
REQ-007 sensor_fault  output  1  high while a committed invalid probe pattern is active.

Function
REQ-008 level_sensors SHALL pass through a two-flop synchronizer before any other use.
REQ-009 Valid (thermometer) patterns SHALL map: 000->11, 001->10, 011->01, 111->00; patterns 010, 100, 101, 110 SHALL be invalid.
REQ-010 FSM SHALL have exactly three states: STABLE, DEBOUNCE, FAULT.
REQ-011 STABLE: when the synchronized sample differs from the last committed pattern, the FSM SHALL latch it as candidate, clear the counter and enter DEBOUNCE.
REQ-012 DEBOUNCE: each cycle the sample equals candidate, the counter SHALL increment; when the sample differs from candidate, it SHALL become the new candidate and the counter SHALL clear.
REQ-013 DEBOUNCE: if the sample returns to the committed pattern before commit, the FSM SHALL return to STABLE (or FAULT if the committed pattern is invalid) with no output change and no pulse.
REQ-014 Commit SHALL occur on the edge where the candidate has been sampled DEBOUNCE_CYCLES consecutive times.
REQ-015 Valid commit: tank_level_status SHALL update, sensor_fault SHALL clear, next state STABLE; level_changed SHALL pulse for one cycle only if the code changed.
REQ-016 Invalid commit: tank_level_status SHALL hold its last valid value, sensor_fault SHALL set, level_changed SHALL stay 0, next state FAULT.
REQ-017 FAULT SHALL behave as STABLE relative to the committed invalid pattern; a different invalid pattern committed SHALL keep sensor_fault high with no pulse.
REQ-018 End-to-end latency: a change stable before edge k SHALL appear on outputs after edge k+2+DEBOUNCE_CYCLES.
REQ-019 Counter SHALL saturate and never wrap.
REQ-020 All outputs SHALL be registered; no combinational path from level_sensors to outputs.

Reset
REQ-021 While rst_n is low at a rising edge: tank_level_status=2'b11, level_changed=0, sensor_fault=0, synchronizer and committed pattern=000, counter=0, state STABLE.
REQ-022 Reset asserted mid-debounce SHALL discard the candidate; no pulse SHALL be produced on the reset edge or the first edge after release.

Structure
REQ-023 Level codes (LEVEL_EMPTY, LEVEL_LOW, LEVEL_MID, LEVEL_FULL) and FSM state encodings SHALL live in shared package water_tank_pkg, used also by the LED-matrix level decoders.
REQ-024 The synchronizer SHALL be a separate sub-module sync_2ff, parameterized by width.
REQ-025 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-026 Reset release with sensors=000 -> status 11, fault 0, no pulse for 20 cycles.
REQ-027 Sensors 000->011 held at edge k (DEBOUNCE_CYCLES=4) -> status 01 and single level_changed pulse after edge k+6.
REQ-028 Sensors 001 toggled to 000 every 2 cycles for 30 cycles -> status stays 11, no pulse.
REQ-029 Sensors 111 committed, then 101 held 10 cycles -> status stays 00, sensor_fault=1 after edge k+6, no pulse; return to 111 -> fault clears after edge k+6, no pulse.
REQ-030 rst_n low for one cycle at debounce count 2 of 000->111 -> status 11, no pulse; sensors still 111 -> commit to 00 with pulse 6 edges after release.

Source files
------------

// File: rtl/water_tank_pkg.sv
// Shared level codes, FSM state encodings and probe-pattern helpers for tank level logic.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package water_tank_pkg;

  // Committed level codes, also consumed by the LED-matrix level decoders.
  localparam logic [1:0] LEVEL_EMPTY = 2'b11;
  localparam logic [1:0] LEVEL_LOW   = 2'b10;
  localparam logic [1:0] LEVEL_MID   = 2'b01;
  localparam logic [1:0] LEVEL_FULL  = 2'b00;

  typedef enum logic [1:0] {
    ST_STABLE   = 2'b00,
    ST_DEBOUNCE = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  // Probes are stacked low->mid->high, so a physically possible pattern is a thermometer code.
  function automatic logic pattern_valid(input logic [2:0] p);
    logic v;
    v = 1'b0;
    case (p)
      3'b000, 3'b001, 3'b011, 3'b111: v = 1'b1;
      default:                        v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] pattern_code(input logic [2:0] p);
    logic [1:0] c;
    c = LEVEL_EMPTY;
    case (p)
      3'b001:  c = LEVEL_LOW;
      3'b011:  c = LEVEL_MID;
      3'b111:  c = LEVEL_FULL;
      default: c = LEVEL_EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing asynchronous inputs into the clk domain.
// Latency: 2 cycles. Backpressure: none, samples every cycle.
// Ports: clk, rst_n (sync, active-low), d_i (async input bus), q_o (synchronized bus).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/water_tank_level_encoder.sv
// Debounces three tank probes and encodes them into a 2-bit level code with fault flag.
// Latency: a change stable before edge k is visible after edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none; outputs are registered levels plus a one-cycle change pulse.
// Ports: clk, rst_n (sync, active-low), level_sensors[2:0] (async probes, 1 = wet),
//        tank_level_status[1:0], level_changed (pulse), sensor_fault (level).
module water_tank_level_encoder
  import water_tank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] level_sensors,
  output logic [1:0] tank_level_status,
  output logic       level_changed,
  output logic       sensor_fault
);

  // The latching edge counts as the first sighting, so commit fires when the
  // counter has already advanced DEBOUNCE_CYCLES-1 times.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sample;
  state_t     state_q;
  logic [2:0] committed_q;
  logic [2:0] cand_q;
  logic [7:0] cnt_q;
  logic [1:0] status_q;
  logic       changed_q;
  logic       fault_q;

  logic       cand_valid;
  logic [1:0] cand_code;
  logic       committed_valid;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (level_sensors),
    .q_o   (sample)
  );

  assign cand_valid      = pattern_valid(cand_q);
  assign cand_code       = pattern_code(cand_q);
  assign committed_valid = pattern_valid(committed_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STABLE;
      committed_q <= 3'b000;
      cand_q      <= 3'b000;
      cnt_q       <= 8'd0;
      status_q    <= LEVEL_EMPTY;
      changed_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      unique case (state_q)
        // FAULT tracks its committed invalid pattern exactly like STABLE does.
        ST_STABLE, ST_FAULT: begin
          if (sample != committed_q) begin
            cand_q  <= sample;
            cnt_q   <= 8'd0;
            state_q <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (sample == committed_q) begin
            // Glitch died out before commit: drop the candidate silently.
            state_q <= committed_valid ? ST_STABLE : ST_FAULT;
          end else if (sample != cand_q) begin
            cand_q <= sample;
            cnt_q  <= 8'd0;
          end else if (cnt_q >= CNT_LAST) begin
            committed_q <= cand_q;
            if (cand_valid) begin
              status_q  <= cand_code;
              changed_q <= (cand_code != status_q);
              fault_q   <= 1'b0;
              state_q   <= ST_STABLE;
            end else begin
              // Status keeps the last good level so consumers never see a bogus code.
              fault_q <= 1'b1;
              state_q <= ST_FAULT;
            end
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_STABLE;
      endcase
    end
  end

  assign tank_level_status = status_q;
  assign level_changed     = changed_q;
  assign sensor_fault      = fault_q;

endmodule

// File: tb/tb_water_tank_level_encoder.sv
module tb_water_tank_level_encoder;
  import water_tank_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sens = 3'b000;
  logic [1:0] status;
  logic       lc;
  logic       fault;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [1:0] cur_status = LEVEL_EMPTY;
  logic       cur_fault = 1'b0;

  water_tank_level_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .level_sensors     (sens),
    .tank_level_status (status),
    .level_changed     (lc),
    .sensor_fault      (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lc === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new pattern just after an edge (edge k is the next one) and check
  // that nothing moves through edge k+5 and the commit lands at edge k+6.
  task automatic expect_commit(input string tag, input logic [2:0] s,
                               input logic [1:0] st, input logic f, input logic p);
    sens = s;
    for (int i = 0; i < 6; i++) begin
      tick();
      check({tag, "_hold_status"}, {6'd0, status}, {6'd0, cur_status});
      check({tag, "_hold_fault"}, {7'd0, fault}, {7'd0, cur_fault});
      check({tag, "_hold_pulse"}, {7'd0, lc}, 8'd0);
    end
    tick();
    check({tag, "_status"}, {6'd0, status}, {6'd0, st});
    check({tag, "_fault"}, {7'd0, fault}, {7'd0, f});
    check({tag, "_pulse"}, {7'd0, lc}, {7'd0, p});
    cur_status = st;
    cur_fault  = f;
    if (p) exp_pulses++;
    tick();
    check({tag, "_pulse_end"}, {7'd0, lc}, 8'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
    check("rst_fault", {7'd0, fault}, 8'd0);
    check("rst_pulse", {7'd0, lc}, 8'd0);

    // Idle after release with dry probes
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
      check("idle_fault", {7'd0, fault}, 8'd0);
      check("idle_pulse", {7'd0, lc}, 8'd0);
    end

    // Low probe chattering every 2 cycles never commits
    for (int i = 0; i < 15; i++) begin
      sens = (i % 2 == 0) ? 3'b001 : 3'b000;
      tick();
      tick();
      check("chatter_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
      check("chatter_pulse", {7'd0, lc}, 8'd0);
    end
    sens = 3'b000;
    repeat (6) tick();
    check("chatter_fault", {7'd0, fault}, 8'd0);

    expect_commit("mid", 3'b011, LEVEL_MID, 1'b0, 1'b1);
    expect_commit("full", 3'b111, LEVEL_FULL, 1'b0, 1'b1);

    // Invalid 101 held 10 cycles total, then back to 111
    expect_commit("flt101", 3'b101, LEVEL_FULL, 1'b1, 1'b0);
    repeat (2) tick();
    check("flt101_held_status", {6'd0, status}, {6'd0, LEVEL_FULL});
    check("flt101_held_fault", {7'd0, fault}, 8'd1);
    expect_commit("clr111", 3'b111, LEVEL_FULL, 1'b0, 1'b0);

    // Invalid to a different invalid keeps the fault, then valid recovery
    expect_commit("flt100", 3'b100, LEVEL_FULL, 1'b1, 1'b0);
    expect_commit("flt110", 3'b110, LEVEL_FULL, 1'b1, 1'b0);
    expect_commit("low", 3'b001, LEVEL_LOW, 1'b0, 1'b1);
    expect_commit("empty", 3'b000, LEVEL_EMPTY, 1'b0, 1'b1);

    // Reset at debounce count 2 of 000->111
    sens = 3'b111;
    repeat (5) tick();
    check("rstdb_pre_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
    rst_n = 1'b0;
    tick();
    check("rstdb_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
    check("rstdb_pulse", {7'd0, lc}, 8'd0);
    check("rstdb_fault", {7'd0, fault}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstrel_status", {6'd0, status}, {6'd0, LEVEL_EMPTY});
      check("rstrel_pulse", {7'd0, lc}, 8'd0);
    end
    tick();
    check("rstrel_commit_status", {6'd0, status}, {6'd0, LEVEL_FULL});
    check("rstrel_commit_pulse", {7'd0, lc}, 8'd1);
    exp_pulses++;
    tick();
    check("rstrel_pulse_end", {7'd0, lc}, 8'd0);

    repeat (2) tick();
    check("pulse_total", 8'(pulses), 8'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
